// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, decoder and Moore sequencer for the lab CPU datapath
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [2:0]  nsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic        w,
    output logic        illegal
);
    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_CALC,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic        illegal_q;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] sh;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       is_mvn;
    logic       is_legal;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign sh     = ir[4:3];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    // Register selection is one-hot via nsel; the Rn field itself is consumed by the datapath
    logic unused_rn;
    assign unused_rn = ^ir[10:8];

    assign sximm8  = {{8{ir[7]}}, ir[7:0]};
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_WAIT;
            ir        <= 16'h0000;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && load) begin
                ir <= in;
            end
            if (state == S_DECODE && !is_legal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        nsel       = 3'b000;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 2'b00;
        shift      = 2'b00;
        ALUop      = 2'b00;
        w          = 1'b0;

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_next = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_next = S_GET_B;
                end else if (is_alu) begin
                    state_next = S_GET_A;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_GET_A: begin
                nsel       = 3'b100;
                loada      = 1'b1;
                state_next = S_GET_B;
            end
            S_GET_B: begin
                nsel       = 3'b001;
                loadb      = 1'b1;
                shift      = sh;
                state_next = S_CALC;
            end
            S_CALC: begin
                shift = sh;
                // Single-operand moves zero the A side so the ALU passes (or inverts) B
                asel  = is_mov_reg || is_mvn;
                ALUop = is_mov_reg ? 2'b00 : op;
                if (is_cmp) begin
                    loads      = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    loadc      = 1'b1;
                    state_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                nsel       = 3'b010;
                vsel       = 2'b00;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            S_WRITE_IMM: begin
                nsel       = 3'b100;
                vsel       = 2'b01;
                write      = 1'b1;
                state_next = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed bench for cpu_controller
module tb_cpu_controller;
    logic        clk;
    logic        reset_n;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic [2:0]  nsel;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic        w;
    logic        illegal;

    int vectors;
    int miscompares;

    cpu_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .load    (load),
        .in      (in),
        .nsel    (nsel),
        .write   (write),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .vsel    (vsel),
        .shift   (shift),
        .ALUop   (ALUop),
        .sximm8  (sximm8),
        .w       (w),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {nsel,write,loada,loadb,loadc,loads,asel,bsel,vsel,shift,ALUop,w,illegal}
    function automatic logic [17:0] ev(input logic [2:0] ns, input logic wr, input logic la,
                                       input logic lb, input logic lc, input logic ls,
                                       input logic as, input logic [1:0] vs, input logic [1:0] sh,
                                       input logic [1:0] op, input logic wt, input logic il);
        return {ns, wr, la, lb, lc, ls, as, 1'b0, vs, sh, op, wt, il};
    endfunction

    task automatic chk(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, w, illegal};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] exp);
        vectors++;
        assert (sximm8 === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%04h expected=%04h", tag, sximm8, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] word);
        in   = word;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
    endtask

    localparam logic [17:0] E_WAIT   = 18'h00002;
    localparam logic [17:0] E_IDLE   = 18'h00000;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        s           = 1'b0;
        load        = 1'b0;
        in          = 16'h0000;
        #12;
        chk("reset_outputs", ev(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        chk16("reset_ir", 16'h0000);
        reset_n = 1'b1;
        tick();
        chk("wait_idle", E_WAIT);

        // MOV R0,#0x69
        start(16'hD069);
        chk("movi_decode", E_IDLE);
        chk16("movi_sximm8", 16'h0069);
        tick();
        chk("movi_write_imm", ev(3'b100, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        tick();
        chk("movi_done", E_WAIT);

        in   = 16'hD0CA;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk16("movi_neg_sximm8", 16'hFFCA);
        chk("load_only_stays_wait", E_WAIT);

        // ADD R1=R2+R1
        start(16'hA221);
        chk("add_decode", E_IDLE);
        tick();
        chk("add_get_a", ev(3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("add_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("add_calc", ev(3'b000, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("add_write_reg", ev(3'b010, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("add_done", E_WAIT);

        // CMP R0,R7 LSL
        start(16'hA84F);
        tick();
        chk("cmp_get_a", ev(3'b100, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("cmp_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0));
        tick();
        chk("cmp_calc", ev(3'b000, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b01, 0, 0));
        tick();
        chk("cmp_done_4_edges", E_WAIT);

        // MOV R1,R0 LSR
        start(16'hC330);
        chk("movr_decode", E_IDLE);
        tick();
        chk("movr_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0));
        tick();
        chk("movr_calc", ev(3'b000, 0, 0, 0, 1, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0));
        tick();
        chk("movr_write_reg", ev(3'b010, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("movr_done", E_WAIT);

        // MVN R3,R4
        start(16'hB864);
        tick();
        chk("mvn_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("mvn_calc", ev(3'b000, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b11, 0, 0));
        tick();
        chk("mvn_write_reg", ev(3'b010, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        chk("mvn_done", E_WAIT);

        // s held high: back-to-back MOV imm
        in   = 16'hD107;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        chk("b2b_decode", E_IDLE);
        tick();
        chk("b2b_write_imm", ev(3'b100, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0));
        tick();
        chk("b2b_wait", E_WAIT);
        tick();
        chk("b2b_restart", E_IDLE);
        s = 1'b0;
        tick();
        tick();
        chk("b2b_finish", E_WAIT);

        // s/load/in toggled while busy must be ignored
        start(16'hA221);
        tick();
        tick();
        chk("busy_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        in   = 16'hD0CA;
        load = 1'b1;
        s    = 1'b1;
        tick();
        load = 1'b0;
        s    = 1'b0;
        chk16("busy_ir_stable", 16'h0021);
        chk("busy_calc", ev(3'b000, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
        tick();
        tick();
        chk("busy_done", E_WAIT);
        tick();
        chk("busy_no_restart", E_WAIT);

        // Illegal opcode
        start(16'hE000);
        chk("ill_decode", E_IDLE);
        tick();
        chk("ill_wait_set", ev(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1));
        start(16'hD001);
        tick();
        chk("ill_sticky_write", ev(3'b100, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 1));
        tick();
        chk("ill_sticky_wait", ev(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1));

        // Asynchronous reset during GET_B of an ADD
        start(16'hA221);
        tick();
        tick();
        chk("rst_pre_get_b", ev(3'b001, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_drop", E_WAIT);
        chk16("rst_ir_cleared", 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_after_release", E_WAIT);
        tick();
        chk("rst_no_writeback", E_WAIT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
